pwm_fade_ctrl: RTL and testbench

PWM_FADE_CTRL -- requirements
Module: pwm_fade_ctrl

---
 rtl/pwm_fade_ctrl.sv | 145 ++++++++++++++
 tb/tb_pwm_fade_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_fade_ctrl.sv
// LED-style fade sequencer: ramps a PWM duty from 0 up to a latched peak,
// dwells there for a latched number of step ticks, then ramps back to 0.
module pwm_fade_ctrl #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int STEP_FREQ = 100,
  parameter int DUTY_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic [DUTY_W-1:0] target,
  input  logic [DUTY_W-1:0] hold_steps,
  output logic              pwm_out,
  output logic [DUTY_W-1:0] duty,
  output logic              busy,
  output logic              done
);

  localparam int STEP_MAX = CLK_FREQ / STEP_FREQ;
  localparam int STEP_W   = (STEP_MAX > 1) ? $clog2(STEP_MAX) : 1;
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_MAX - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    HOLD = 2'd2,
    DOWN = 2'd3
  } state_t;

  state_t            state_reg,    state_next;
  logic [DUTY_W-1:0] duty_reg,     duty_next;
  logic [DUTY_W-1:0] pcnt_reg,     pcnt_next;
  logic [STEP_W-1:0] step_cnt_reg, step_cnt_next;
  logic [DUTY_W-1:0] hold_cnt_reg, hold_cnt_next;
  logic [DUTY_W-1:0] target_l_reg, target_l_next;
  logic [DUTY_W-1:0] hold_l_reg,   hold_l_next;
  logic              pwm_reg,      pwm_next;
  logic              done_reg,     done_next;
  logic              step_tick;

  // Free-running PWM carrier and registered comparator.
  always_comb begin
    pcnt_next = pcnt_reg + DUTY_W'(1);
    pwm_next  = (duty_reg > pcnt_reg);
  end

  // Step prescaler only runs while a fade is active, so the first tick after
  // start always lands exactly STEP_MAX cycles later.
  always_comb begin
    step_tick     = (state_reg != IDLE) && (step_cnt_reg == STEP_LAST);
    step_cnt_next = step_cnt_reg + STEP_W'(1);
    if (state_reg == IDLE) begin
      step_cnt_next = '0;
    end else if (step_tick) begin
      step_cnt_next = '0;
    end
  end

  always_comb begin
    state_next    = state_reg;
    duty_next     = duty_reg;
    hold_cnt_next = hold_cnt_reg;
    target_l_next = target_l_reg;
    hold_l_next   = hold_l_reg;
    done_next     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start && !stop) begin
          target_l_next = target;
          hold_l_next   = hold_steps;
          duty_next     = '0;
          state_next    = UP;
        end
      end
      UP: begin
        // An abort takes precedence over a coincident step tick.
        if (stop) begin
          state_next = DOWN;
        end else if (step_tick) begin
          if (duty_reg == target_l_reg) begin
            state_next    = HOLD;
            hold_cnt_next = '0;
          end else begin
            duty_next = duty_reg + DUTY_W'(1);
          end
        end
      end
      HOLD: begin
        if (stop) begin
          state_next = DOWN;
        end else if (step_tick) begin
          if (hold_cnt_reg == hold_l_reg) begin
            state_next = DOWN;
          end else begin
            hold_cnt_next = hold_cnt_reg + DUTY_W'(1);
          end
        end
      end
      DOWN: begin
        if (step_tick) begin
          if (duty_reg == '0) begin
            state_next = IDLE;
            done_next  = 1'b1;
          end else begin
            duty_next = duty_reg - DUTY_W'(1);
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg    <= IDLE;
      duty_reg     <= '0;
      pcnt_reg     <= '0;
      step_cnt_reg <= '0;
      hold_cnt_reg <= '0;
      target_l_reg <= '0;
      hold_l_reg   <= '0;
      pwm_reg      <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      duty_reg     <= duty_next;
      pcnt_reg     <= pcnt_next;
      step_cnt_reg <= step_cnt_next;
      hold_cnt_reg <= hold_cnt_next;
      target_l_reg <= target_l_next;
      hold_l_reg   <= hold_l_next;
      pwm_reg      <= pwm_next;
      done_reg     <= done_next;
    end
  end

  assign pwm_out = pwm_reg;
  assign duty    = duty_reg;
  assign busy    = (state_reg != IDLE);
  assign done    = done_reg;

endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// Scoreboard bench for pwm_fade_ctrl (STEP_MAX = 4): stimulus queues the
// expected busy/duty/done events with their cycle numbers, a monitor checks them.
module tb_pwm_fade_ctrl;

  localparam int DW      = 8;
  localparam int EV_BUSY = 0;
  localparam int EV_DUTY = 1;
  localparam int EV_DONE = 2;

  typedef struct {
    int kind;
    int val;
    int cyc;
  } ev_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic [DW-1:0] target = '0;
  logic [DW-1:0] hold_steps = '0;
  logic          pwm_out;
  logic [DW-1:0] duty;
  logic          busy;
  logic          done;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int pwm_hi = 0;
  bit mon_en = 1'b0;
  logic          prev_busy = 1'b0;
  logic [DW-1:0] prev_duty = '0;
  ev_t exp_q[$];

  pwm_fade_ctrl #(
    .CLK_FREQ (40),
    .STEP_FREQ(10),
    .DUTY_W   (DW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .target    (target),
    .hold_steps(hold_steps),
    .pwm_out   (pwm_out),
    .duty      (duty),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  // cyc == k while observing the state produced by rising edge k.
  always @(posedge clk) cyc++;

  function automatic string kname(input int k);
    if (k == EV_BUSY) return "busy";
    if (k == EV_DUTY) return "duty";
    return "done";
  endfunction

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push(input int kind, input int val, input int c);
    ev_t e;
    e.kind = kind;
    e.val  = val;
    e.cyc  = c;
    exp_q.push_back(e);
  endtask

  task automatic observe(input int kind, input int val);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL unexpected_%s: got %0d at cycle %0d, expected no event", kname(kind), val, cyc);
    end else begin
      e = exp_q.pop_front();
      check({"event_kind_", kname(e.kind)}, kind, e.kind);
      check({"event_value_", kname(e.kind)}, val, e.val);
      check({"event_cycle_", kname(e.kind)}, cyc, e.cyc);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (busy != prev_busy) observe(EV_BUSY, int'(busy));
      if (duty != prev_duty) observe(EV_DUTY, int'(duty));
      if (done) observe(EV_DONE, 1);
      if (pwm_out) pwm_hi++;
      prev_busy = busy;
      prev_duty = duty;
    end
  end

  // Returns at the falling edge just before rising edge k, ready to drive for it.
  task automatic at_edge(input int k);
    @(negedge clk);
    while (cyc < k - 1) @(negedge clk);
  endtask

  task automatic launch(input int tgt, input int hld, output int n);
    @(negedge clk);
    start      = 1'b1;
    target     = tgt[DW-1:0];
    hold_steps = hld[DW-1:0];
    n          = cyc + 1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int r;
    int p0;
    int hi;

    repeat (3) @(negedge clk);
    check("reset_duty", int'(duty), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_pwm", int'(pwm_out), 0);
    check("reset_done", int'(done), 0);
    rst = 1'b1;
    prev_busy = 1'b0;
    prev_duty = '0;
    mon_en = 1'b1;
    repeat (2) @(negedge clk);

    // Full cycle: target 3, hold 2.
    launch(3, 2, n);
    push(EV_BUSY, 1, n);
    push(EV_DUTY, 1, n + 4);
    push(EV_DUTY, 2, n + 8);
    push(EV_DUTY, 3, n + 12);
    push(EV_DUTY, 2, n + 32);
    push(EV_DUTY, 1, n + 36);
    push(EV_DUTY, 0, n + 40);
    push(EV_BUSY, 0, n + 44);
    push(EV_DONE, 1, n + 44);
    at_edge(n + 1);
    start = 1'b0;
    at_edge(n + 50);

    // Stop during UP at duty 2.
    launch(5, 1, n);
    push(EV_BUSY, 1, n);
    push(EV_DUTY, 1, n + 4);
    push(EV_DUTY, 2, n + 8);
    push(EV_DUTY, 1, n + 12);
    push(EV_DUTY, 0, n + 16);
    push(EV_BUSY, 0, n + 20);
    push(EV_DONE, 1, n + 20);
    at_edge(n + 1);
    start = 1'b0;
    at_edge(n + 9);
    stop = 1'b1;
    at_edge(n + 10);
    stop = 1'b0;
    at_edge(n + 26);

    // Zero target and zero hold: three consecutive ticks back to IDLE.
    launch(0, 0, n);
    p0 = pwm_hi;
    push(EV_BUSY, 1, n);
    push(EV_BUSY, 0, n + 12);
    push(EV_DONE, 1, n + 12);
    at_edge(n + 1);
    start = 1'b0;
    at_edge(n + 16);
    check("zero_target_pwm_high_cycles", pwm_hi - p0, 0);
    check("zero_target_duty", int'(duty), 0);

    // start together with stop in IDLE is refused.
    @(negedge clk);
    start  = 1'b1;
    stop   = 1'b1;
    target = 8'd9;
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
    repeat (8) @(negedge clk);
    check("start_stop_idle_busy", int'(busy), 0);

    // start pulsed during HOLD with new operands has no effect.
    launch(2, 3, n);
    push(EV_BUSY, 1, n);
    push(EV_DUTY, 1, n + 4);
    push(EV_DUTY, 2, n + 8);
    push(EV_DUTY, 1, n + 32);
    push(EV_DUTY, 0, n + 36);
    push(EV_BUSY, 0, n + 40);
    push(EV_DONE, 1, n + 40);
    at_edge(n + 1);
    start = 1'b0;
    at_edge(n + 14);
    start      = 1'b1;
    target     = 8'd7;
    hold_steps = 8'd0;
    at_edge(n + 15);
    start = 1'b0;
    at_edge(n + 46);

    // Reset in the middle of HOLD at duty 5.
    launch(5, 10, n);
    push(EV_BUSY, 1, n);
    for (int k = 1; k <= 5; k++) push(EV_DUTY, k, n + 4 * k);
    push(EV_BUSY, 0, n + 30);
    push(EV_DUTY, 0, n + 30);
    at_edge(n + 1);
    start = 1'b0;
    at_edge(n + 30);
    rst = 1'b0;
    at_edge(n + 31);
    check("midhold_reset_pwm", int'(pwm_out), 0);
    check("midhold_reset_busy", int'(busy), 0);
    check("midhold_reset_done", int'(done), 0);

    // Start in the first cycle after reset release; peak 128 then abort from HOLD.
    rst        = 1'b1;
    start      = 1'b1;
    target     = 8'd128;
    hold_steps = 8'd255;
    r          = cyc + 1;
    push(EV_BUSY, 1, r);
    for (int k = 1; k <= 128; k++) push(EV_DUTY, k, r + 4 * k);
    for (int j = 1; j <= 128; j++) push(EV_DUTY, 128 - j, r + 800 + 4 * j);
    push(EV_BUSY, 0, r + 1316);
    push(EV_DONE, 1, r + 1316);
    at_edge(r + 1);
    start = 1'b0;
    at_edge(r + 521);
    check("peak_duty", int'(duty), 128);
    hi = 0;
    for (int i = 0; i < 256; i++) begin
      if (pwm_out) hi++;
      @(negedge clk);
    end
    check("pwm_high_per_period_duty128", hi, 128);
    at_edge(r + 802);
    stop = 1'b1;
    at_edge(r + 803);
    stop = 1'b0;
    at_edge(r + 1325);

    check("events_left_pending", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
